// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: decode-side control and program-memory signals of the fetch sequencer
interface fetch_sequencer_if #(
   parameter int program_code_size = 8,
   parameter int instruction_size = 16
);
   logic                         start;
   logic                         stall;
   logic                         branch_taken;
   logic                         branch_absolute;
   logic [program_code_size-1:0] branch_target;
   logic                         halt;
   logic [instruction_size-1:0]  instruction_code;
   logic [program_code_size-1:0] address;
   logic [instruction_size-1:0]  ir;
   logic                         ir_valid;
   logic [program_code_size-1:0] ir_pc;
   logic [1:0]                   state;
   logic                         wrapped;
   modport master (
      input  start, stall, branch_taken, branch_absolute, branch_target, halt, instruction_code,
      output address, ir, ir_valid, ir_pc, state, wrapped
   );
   modport slave (
      output start, stall, branch_taken, branch_absolute, branch_target, halt, instruction_code,
      input  address, ir, ir_valid, ir_pc, state, wrapped
   );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: picoMIPS program counter and instruction register with stall, branch, halt and wrap tracking
module fetch_sequencer #(
   parameter int program_code_size = 8,
   parameter int instruction_size = 16
) (
   input logic clk,
   input logic n_reset,
   fetch_sequencer_if.master bus
);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STALL = 2'b10, HALT = 2'b11} state_t;
   state_t                       state_q, state_d;
   logic [program_code_size-1:0] pc_q, pc_d, ir_pc_q, ir_pc_d;
   logic [instruction_size-1:0]  ir_q, ir_d;
   logic                         ir_valid_q, ir_valid_d, wrapped_q, wrapped_d;
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         ir_pc_q    <= '0;
         wrapped_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         ir_pc_q    <= ir_pc_d;
         wrapped_q  <= wrapped_d;
      end
   end
   // halt and branch only act on a live IR; relative targets wrap naturally at PC width
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      ir_pc_d    = ir_pc_q;
      wrapped_d  = wrapped_q;
      if (state_q == IDLE || state_q == HALT) begin
         ir_valid_d = 1'b0;
         if (bus.start) begin
            state_d   = RUN;
            pc_d      = '0;
            wrapped_d = 1'b0;
         end
      end else if (bus.halt && ir_valid_q) begin
         state_d    = HALT;
         ir_valid_d = 1'b0;
      end else if (bus.branch_taken && ir_valid_q) begin
         state_d    = RUN;
         ir_valid_d = 1'b0;
         pc_d       = bus.branch_absolute ? bus.branch_target : ir_pc_q + bus.branch_target;
      end else if (bus.stall) begin
         state_d = STALL;
      end else begin
         state_d    = RUN;
         ir_d       = bus.instruction_code;
         ir_pc_d    = pc_q;
         ir_valid_d = 1'b1;
         pc_d       = pc_q + program_code_size'(1);
         wrapped_d  = wrapped_q | (&pc_q);
      end
   end
   assign bus.address  = pc_q;
   assign bus.ir       = ir_q;
   assign bus.ir_valid = ir_valid_q;
   assign bus.ir_pc    = ir_pc_q;
   assign bus.state    = state_q;
   assign bus.wrapped  = wrapped_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with a queued expected-state scoreboard
module tb_fetch_sequencer;
   logic clk = 1'b0;
   logic n_reset;
   int   checks = 0;
   int   failures = 0;
   int   step = 0;
   typedef struct packed {
      logic [7:0]  a;
      logic [15:0] i;
      logic        v;
      logic [7:0]  p;
      logic [1:0]  s;
      logic        w;
   } exp_t;
   exp_t sb[$];
   fetch_sequencer_if #(.program_code_size(8), .instruction_size(16)) bus ();
   fetch_sequencer #(.program_code_size(8), .instruction_size(16)) dut (
      .clk(clk),
      .n_reset(n_reset),
      .bus(bus)
   );
   always #5 clk = ~clk;
   assign bus.instruction_code = 16'h1000 + 16'(bus.address);
   function automatic exp_t actual();
      return '{bus.address, bus.ir, bus.ir_valid, bus.ir_pc, bus.state, bus.wrapped};
   endfunction
   task automatic cmp(input string name, input exp_t got, input exp_t want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got a=%h ir=%h v=%b pc=%h s=%b w=%b want a=%h ir=%h v=%b pc=%h s=%b w=%b",
                  name, got.a, got.i, got.v, got.p, got.s, got.w, want.a, want.i, want.v, want.p, want.s, want.w);
      end
   endtask
   task automatic go(input logic st, stl, bt, ba, input logic [7:0] tg, input logic hl,
                     input logic [7:0] a, input logic [15:0] i, input logic v,
                     input logic [7:0] p, input logic [1:0] s, input logic w);
      bus.start = st;
      bus.stall = stl;
      bus.branch_taken = bt;
      bus.branch_absolute = ba;
      bus.branch_target = tg;
      bus.halt = hl;
      sb.push_back('{a, i, v, p, s, w});
      @(posedge clk);
      @(negedge clk);
   endtask
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            step++;
            cmp($sformatf("step%0d", step), actual(), e);
         end
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end
   initial begin
      n_reset = 1'b0;
      bus.start = 0; bus.stall = 0; bus.branch_taken = 0; bus.branch_absolute = 0;
      bus.branch_target = 8'h00; bus.halt = 0;
      #2;
      cmp("reset", actual(), '0);
      @(negedge clk);
      n_reset = 1'b1;
      //  st stl bt ba tgt    hl  addr   ir        v  irpc   st     w
      go(1, 0, 0, 0, 8'h00, 0, 8'h00, 16'h0000, 0, 8'h00, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'h01, 16'h1000, 1, 8'h00, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'h02, 16'h1001, 1, 8'h01, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'h03, 16'h1002, 1, 8'h02, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'h04, 16'h1003, 1, 8'h03, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'h05, 16'h1004, 1, 8'h04, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'h06, 16'h1005, 1, 8'h05, 2'b01, 0);
      go(0, 1, 0, 0, 8'h00, 0, 8'h06, 16'h1005, 1, 8'h05, 2'b10, 0);
      go(0, 1, 0, 0, 8'h00, 0, 8'h06, 16'h1005, 1, 8'h05, 2'b10, 0);
      go(0, 1, 0, 0, 8'h00, 0, 8'h06, 16'h1005, 1, 8'h05, 2'b10, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'h07, 16'h1006, 1, 8'h06, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'h08, 16'h1007, 1, 8'h07, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'h09, 16'h1008, 1, 8'h08, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'h0A, 16'h1009, 1, 8'h09, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'h0B, 16'h100A, 1, 8'h0A, 2'b01, 0);
      go(0, 0, 1, 0, 8'hFC, 0, 8'h06, 16'h100A, 0, 8'h0A, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'h07, 16'h1006, 1, 8'h06, 2'b01, 0);
      go(0, 1, 1, 1, 8'h40, 0, 8'h40, 16'h1006, 0, 8'h06, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'h41, 16'h1040, 1, 8'h40, 2'b01, 0);
      go(0, 0, 1, 1, 8'hFD, 0, 8'hFD, 16'h1040, 0, 8'h40, 2'b01, 0);
      go(0, 0, 1, 1, 8'h10, 0, 8'hFE, 16'h10FD, 1, 8'hFD, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'hFF, 16'h10FE, 1, 8'hFE, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'h00, 16'h10FF, 1, 8'hFF, 2'b01, 1);
      go(0, 0, 0, 0, 8'h00, 0, 8'h01, 16'h1000, 1, 8'h00, 2'b01, 1);
      go(1, 0, 0, 0, 8'h00, 0, 8'h02, 16'h1001, 1, 8'h01, 2'b01, 1);
      go(0, 0, 0, 0, 8'h00, 1, 8'h02, 16'h1001, 0, 8'h01, 2'b11, 1);
      go(0, 1, 1, 1, 8'h80, 1, 8'h02, 16'h1001, 0, 8'h01, 2'b11, 1);
      go(1, 0, 0, 0, 8'h00, 0, 8'h00, 16'h1001, 0, 8'h01, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'h01, 16'h1000, 1, 8'h00, 2'b01, 0);
      go(0, 0, 1, 0, 8'hFE, 0, 8'hFE, 16'h1000, 0, 8'h00, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'hFF, 16'h10FE, 1, 8'hFE, 2'b01, 0);
      go(0, 0, 1, 1, 8'h20, 0, 8'h20, 16'h10FE, 0, 8'hFE, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'h21, 16'h1020, 1, 8'h20, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'h22, 16'h1021, 1, 8'h21, 2'b01, 0);
      go(0, 0, 0, 0, 8'h00, 0, 8'h23, 16'h1022, 1, 8'h22, 2'b01, 0);
      #2;
      n_reset = 1'b0;
      #1;
      cmp("async_reset", actual(), '0);
      @(negedge clk);
      n_reset = 1'b1;
      go(0, 0, 0, 0, 8'h00, 0, 8'h00, 16'h0000, 0, 8'h00, 2'b00, 0);
      go(1, 0, 0, 0, 8'h00, 0, 8'h00, 16'h0000, 0, 8'h00, 2'b01, 0);
      go(0, 0, 1, 1, 8'h55, 1, 8'h01, 16'h1000, 1, 8'h00, 2'b01, 0);
      @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain got %0d pending want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for picoMIPS. Owns the program counter and drives the `address` input of `program_memory`.
- `program_memory` is combinational: `address` in, `instruction_code` out in the same cycle.
- Registers `instruction_code` into an instruction register (IR) with a valid flag for the decode stage.
- Handles start, stall, absolute/relative branch with flush, halt, and PC wrap-around.

Parameters:
program_code_size, 8, PC/address width; program space is 2^program_code_size words (codebase value `PROGRAM_CODE_SIZE`)
instruction_size, 16, instruction word width (codebase value `INSTRUCTION_SIZE`)

Ports:
clk  input  1  system clock, rising edge
n_reset  input  1  asynchronous active-low reset
start  input  1  begin execution at address 0 (IDLE or HALT only)
stall  input  1  hold PC and IR this cycle
branch_taken  input  1  decode resolves the instruction in IR as a taken branch
branch_absolute  input  1  1: branch_target is absolute; 0: signed offset from ir_pc
branch_target  input  program_code_size  absolute address or two's-complement offset
halt  input  1  decode resolves the instruction in IR as a halt
instruction_code  input  instruction_size  data from program_memory
address  output  program_code_size  current PC, to program_memory
ir  output  instruction_size  instruction register
ir_valid  output  1  ir holds a live instruction
ir_pc  output  program_code_size  address from which ir was fetched
state  output  2  00 IDLE, 01 RUN, 10 STALL, 11 HALT
wrapped  output  1  sticky: PC rolled from max to 0 since last start

Behaviour:
- Reset (asynchronous, n_reset=0): address=0, ir=0, ir_valid=0, ir_pc=0, state=IDLE, wrapped=0. Reset mid-RUN aborts at once; no partial fetch survives.
- address is the PC register directly, so the memory read completes in the same cycle. Fetch latency is 1 cycle: the word at PC appears on ir after the next rising edge.
- IDLE:
  - PC held at 0; ir_valid=0.
  - start=1 -> RUN next edge, with PC=0 and wrapped cleared.
- RUN/STALL: evaluate per edge in strict priority order:
  1. halt & ir_valid -> HALT; ir_valid<=0; PC held.
  2. branch_taken & ir_valid -> PC<=target; ir_valid<=0 (one-cycle flush bubble); state RUN. This applies even if stall=1.
     - Target is branch_target when branch_absolute=1.
     - Otherwise target is (ir_pc + sign-extended branch_target) mod 2^program_code_size.
  3. stall -> PC, ir, ir_valid, ir_pc unchanged; state STALL. Leaving stall returns to RUN on the next edge.
  4. Otherwise: ir<=instruction_code; ir_pc<=PC; ir_valid<=1; PC<=PC+1; state RUN.
- halt and branch_taken are ignored while ir_valid=0 (the bubble or first cycle).
- Wrap-around: PC=2^program_code_size-1 increments to 0 and sets wrapped<=1. Execution continues; wrapped clears only on start or reset. Relative branch arithmetic also wraps modulo 2^program_code_size but does not set wrapped.
- HALT:
  - PC, ir, and ir_pc frozen; ir_valid=0.
  - start=1 -> RUN from address 0, wrapped cleared.
  - All other inputs ignored.
- start is ignored in RUN/STALL.
- All outputs are registered except address, which equals the PC register.

Test Plan:
- Reset then start, memory word[i]=16'h1000+i -> address 0,1,2,3 on consecutive cycles. ir=16'h1000 with ir_valid=1 and ir_pc=0 one cycle after entering RUN; state=01.
- Stall held 3 cycles while ir_pc=5 -> state=10, address stays 6, ir/ir_pc unchanged. Stall release -> ir_pc=6 next edge.
- branch_taken with ir_pc=10:
  - Relative, offset 8'hFC -> next address 6, ir_valid=0 for one cycle, then ir_pc=6.
  - Absolute, target 8'h40 -> address 0x40.
  - branch_taken and stall together -> branch wins.
- Run through address 0xFF -> address returns to 0x00 and wrapped=1. Subsequent start from HALT clears wrapped.
- halt asserted with ir_valid=1 -> state=11, ir_valid=0, address frozen, branch_taken ignored. start -> address 0, state=01.
- n_reset pulsed low asynchronously mid-RUN at address 0x23 -> all outputs zero and state=00 immediately, without waiting for a clock edge.
